// File: rtl/ai_op_sequencer.sv
// Sequences one multi-cycle AI op at a time: accept -> start pulse -> wait for done -> one writeback.
// The start pulse comes one cycle after accept and writeback one cycle after done; the pipeline is stalled from accept until done, and a flush drains the unit without a writeback.
module ai_op_sequencer #(
  parameter int                  OPW     = 3,
  parameter logic [(1<<OPW)-1:0] MC_MASK = 8'b0000_0010,
  parameter int                  TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic [OPW-1:0] req_opcode,
  input  logic [4:0]     req_rd,
  input  logic           flush,
  input  logic           unit_done,
  input  logic [31:0]    unit_result,
  output logic           unit_start,
  output logic           stall,
  output logic           busy,
  output logic           wb_valid,
  output logic [4:0]     wb_rd,
  output logic [31:0]    wb_data,
  output logic           timeout_err
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          unit_start_q, unit_start_d;
  logic          wb_valid_q, wb_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          accept;
  logic          timeout_hit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    timeout_err_d = timeout_err_q;
    accept        = (state_q == S_IDLE) && req_valid && MC_MASK[req_opcode] && !flush;
    timeout_hit   = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d    = req_rd;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = '0;
        if (flush) begin
          state_d = S_DRAIN;
        end else if (unit_done) begin
          wb_data_d = unit_result;
          wb_rd_d   = rd_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Flush wins over a same-cycle done: the op is squashed either way.
        if (flush) begin
          state_d = S_DRAIN;
        end else if (unit_done) begin
          wb_data_d = unit_result;
          wb_rd_d   = rd_q;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // The watchdog budget keeps running across WAIT and DRAIN.
        cnt_d = cnt_q + CW'(1);
        if (unit_done) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    unit_start_d = (state_d == S_START);
    wb_valid_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_q          <= '0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      unit_start_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      unit_start_q  <= unit_start_d;
      wb_valid_q    <= wb_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign unit_start  = unit_start_q;
  assign stall       = accept || (state_q == S_START) || (state_q == S_WAIT);
  assign busy        = (state_q != S_IDLE);
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ai_op_sequencer.sv
// Bench for ai_op_sequencer: directed and random ops checked cycle by cycle against
// an expected timeline derived from the accept/start/done/flush/timeout rules.
module tb_ai_op_sequencer;

  localparam int         OPW     = 3;
  localparam logic [7:0] MC_MASK = 8'b0000_0010;
  localparam int         T       = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_opcode;
  logic [4:0]  req_rd;
  logic        flush;
  logic        unit_done;
  logic [31:0] unit_result;
  logic        unit_start;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  model_rd;
  logic [31:0] model_data;
  logic        model_tmo;

  always #5 clk = ~clk;

  ai_op_sequencer #(.OPW(OPW), .MC_MASK(MC_MASK), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_rd(req_rd), .flush(flush), .unit_done(unit_done), .unit_result(unit_result),
    .unit_start(unit_start), .stall(stall), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .timeout_err(timeout_err)
  );

  // dd: cycles after the start cycle at which done pulses (-1 = never).
  // fa: cycles after the start cycle at which flush pulses (-1 = never, -2 = with the request).
  task automatic run_op(input string name, input logic [2:0] op, input logic [4:0] rd,
                        input logic [31:0] data, input int dd, input int fa);
    bit acc, flushed, done_ok, wb;
    int end_c, stall_end, busy_end, hold_end;
    bit e_start, e_stall, e_busy, e_wb;
    acc      = MC_MASK[op] && (fa != -2);
    flushed  = acc && (fa >= 0) && ((dd < 0) || (fa <= dd));
    done_ok  = flushed ? ((dd > fa) && (dd <= T)) : ((dd >= 0) && (dd <= T));
    end_c    = 1 + (done_ok ? dd : T);
    stall_end = flushed ? 1 + fa : end_c;
    wb       = acc && done_ok && !flushed;
    busy_end = wb ? end_c + 1 : end_c;
    hold_end = acc ? busy_end : 0;
    for (int c = 0; c < T + 7; c++) begin
      @(posedge clk); #1;
      req_valid   = (c <= hold_end);
      req_opcode  = op;
      req_rd      = rd;
      flush       = ((fa >= 0) && (c == 1 + fa)) || ((fa == -2) && (c == 0));
      unit_done   = (dd >= 0) && (c == 1 + dd);
      unit_result = unit_done ? data : $urandom;
      e_start = acc && (c == 1);
      e_stall = acc && (c <= stall_end);
      e_busy  = acc && (c >= 1) && (c <= busy_end);
      e_wb    = wb && (c == end_c + 1);
      if (e_wb) begin
        model_rd   = rd;
        model_data = data;
      end
      if (acc && !done_ok && (c == end_c + 1)) model_tmo = 1'b1;
      @(negedge clk);
      checks++;
      if (unit_start !== e_start) begin
        errors++; $display("FAIL %s c=%0d unit_start got %b exp %b", name, c, unit_start, e_start);
      end
      checks++;
      if (stall !== e_stall) begin
        errors++; $display("FAIL %s c=%0d stall got %b exp %b", name, c, stall, e_stall);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL %s c=%0d busy got %b exp %b", name, c, busy, e_busy);
      end
      checks++;
      if (wb_valid !== e_wb) begin
        errors++; $display("FAIL %s c=%0d wb_valid got %b exp %b", name, c, wb_valid, e_wb);
      end
      checks++;
      if (wb_rd !== model_rd) begin
        errors++; $display("FAIL %s c=%0d wb_rd got %0d exp %0d", name, c, wb_rd, model_rd);
      end
      checks++;
      if (wb_data !== model_data) begin
        errors++; $display("FAIL %s c=%0d wb_data got %h exp %h", name, c, wb_data, model_data);
      end
      checks++;
      if (timeout_err !== model_tmo) begin
        errors++; $display("FAIL %s c=%0d timeout_err got %b exp %b", name, c, timeout_err, model_tmo);
      end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    unit_done = 1'b0;
  endtask

  task automatic test_reset_values();
    reset = 1'b1; req_valid = 1'b0; req_opcode = '0; req_rd = '0;
    flush = 1'b0; unit_done = 1'b0; unit_result = '0;
    model_rd = '0; model_data = '0; model_tmo = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({unit_start, stall, busy, wb_valid, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {unit_start, stall, busy, wb_valid, timeout_err});
    end
    checks++;
    if ({wb_rd, wb_data} !== 37'd0) begin
      errors++; $display("FAIL reset_wb got rd=%0d data=%h exp 0", wb_rd, wb_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_op("basic", 3'b001, 5'd5, 32'hDEADBEEF, 4, -1);
  endtask

  task automatic test_non_mc();
    run_op("non_mc", 3'b010, 5'd7, 32'h1234_5678, -1, -1);
  endtask

  task automatic test_timeout();
    run_op("timeout", 3'b001, 5'd3, 32'h0BAD_0BAD, -1, -1);
    run_op("after_timeout", 3'b001, 5'd11, 32'hCAFE_F00D, 2, -1);
  endtask

  task automatic test_flush();
    run_op("flush_wait", 3'b001, 5'd12, 32'h5555_AAAA, 5, 2);
    run_op("flush_start", 3'b001, 5'd13, 32'h7777_0000, 3, 0);
    run_op("flush_idle", 3'b001, 5'd14, 32'h1111_2222, -1, -2);
    run_op("flush_done", 3'b001, 5'd15, 32'h3333_4444, 2, 3);
  endtask

  task automatic test_back_to_back();
    run_op("start_done", 3'b001, 5'd21, 32'h0000_0001, 0, -1);
    run_op("b2b", 3'b001, 5'd22, 32'hA5A5_5A5A, 1, -1);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = 3'b001; req_rd = 5'd9; flush = 1'b0; unit_done = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL areset_pre busy got %b exp 1", busy);
    end
    @(posedge clk); #3;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    checks++;
    if ({unit_start, stall, busy, wb_valid, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL areset_flags got %b exp 00000", {unit_start, stall, busy, wb_valid, timeout_err});
    end
    checks++;
    if ({wb_rd, wb_data} !== 37'd0) begin
      errors++; $display("FAIL areset_wb got rd=%0d data=%h exp 0", wb_rd, wb_data);
    end
    @(negedge clk);
    reset = 1'b0;
    model_rd = '0; model_data = '0; model_tmo = 1'b0;
    run_op("post_reset", 3'b001, 5'd30, 32'h0F0F_0F0F, 3, -1);
  endtask

  task automatic test_random();
    logic [2:0] op;
    int dd, fa, r;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
      dd = int'($urandom_range(0, T + 3)) - 1;
      r  = $urandom_range(0, 9);
      if (r < 6)      fa = -1;
      else if (r < 9) fa = $urandom_range(0, T - 1);
      else            fa = -2;
      run_op("random", op, 5'($urandom), $urandom, dd, fa);
    end
  endtask

  initial begin
    test_reset_values();
    test_basic();
    test_non_mc();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
